// File: rtl/bundler_stream.sv
// Sequential majority bundler: accumulates a valid/ready stream of hypervectors into
// per-bit ones-counters and emits the binarized majority vector on an output handshake.
module bundler_stream #(
    parameter int unsigned DIMENSIONS = 10000,
    parameter int unsigned MAX_HVS    = 17,
    parameter int unsigned TIE_MODE   = 0,
    localparam int unsigned CW        = $clog2(MAX_HVS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIMENSIONS-1:0] in_hv,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIMENSIONS-1:0] out_hv,
    output logic [CW-1:0]         out_count,
    output logic                  out_trunc
);

    typedef enum logic [1:0] {StIdle, StAcc, StBin, StEmit} state_e;

    state_e                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [DIMENSIONS-1:0] out_hv_q, out_hv_d;
    logic [CW-1:0]         out_count_q, out_count_d;
    logic                  out_trunc_q, out_trunc_d;
    logic [CW-1:0]         n_q, n_d;
    logic [DIMENSIONS-1:0] first_q, first_d;
    logic [DIMENSIONS-1:0] last_q, last_d;
    logic                  trunc_q, trunc_d;

    logic                  accept;
    logic                  cnt_load, cnt_inc, cnt_clr;
    logic [CW:0]           n_ext, n_plus;
    logic [DIMENSIONS-1:0] vote;

    assign accept = in_valid && in_ready_q;
    assign n_ext  = {1'b0, n_q};
    assign n_plus = n_ext + (CW+1)'(1);

    // One counter per bit; 2*ones vs n decides the vote, ties look at the next bit up.
    for (genvar g = 0; g < DIMENSIONS; g++) begin : g_bit
        localparam int unsigned NextBit = (g + 1) % DIMENSIONS;
        logic [CW-1:0] ones_q, ones_d;
        logic [CW:0]   twice;
        logic          tie_bit;

        always_comb begin
            ones_d = ones_q;
            if (cnt_clr) begin
                ones_d = '0;
            end else if (cnt_load) begin
                ones_d = CW'(in_hv[g]);
            end else if (cnt_inc) begin
                ones_d = ones_q + CW'(in_hv[g]);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ones_q <= '0;
            end else begin
                ones_q <= ones_d;
            end
        end

        assign twice   = {ones_q, 1'b0};
        assign tie_bit = (TIE_MODE == 0) ? (first_q[NextBit] ^ last_q[NextBit]) : 1'b0;
        assign vote[g] = (twice > n_ext) ? 1'b1 : ((twice < n_ext) ? 1'b0 : tie_bit);
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_hv_d    = out_hv_q;
        out_count_d = out_count_q;
        out_trunc_d = out_trunc_q;
        n_d         = n_q;
        first_d     = first_q;
        last_d      = last_q;
        trunc_d     = trunc_q;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    n_d      = CW'(1);
                    first_d  = in_hv;
                    last_d   = in_hv;
                    if (in_last || MAX_HVS == 1) begin
                        state_d    = StBin;
                        in_ready_d = 1'b0;
                        trunc_d    = !in_last;
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            StAcc: begin
                if (accept) begin
                    cnt_inc = 1'b1;
                    n_d     = n_q + CW'(1);
                    last_d  = in_hv;
                    if (in_last || n_plus == (CW+1)'(MAX_HVS)) begin
                        state_d    = StBin;
                        in_ready_d = 1'b0;
                        trunc_d    = !in_last;
                    end
                end
            end
            StBin: begin
                out_hv_d    = vote;
                out_count_d = n_q;
                out_trunc_d = trunc_q;
                state_d     = StEmit;
            end
            StEmit: begin
                // First EMIT cycle only raises out_valid so results are stable when it rises.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_clr     = 1'b1;
                    n_d         = '0;
                    trunc_d     = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_hv_q    <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
            n_q         <= '0;
            first_q     <= '0;
            last_q      <= '0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_hv_q    <= out_hv_d;
            out_count_q <= out_count_d;
            out_trunc_q <= out_trunc_d;
            n_q         <= n_d;
            first_q     <= first_d;
            last_q      <= last_d;
            trunc_q     <= trunc_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_hv    = out_hv_q;
    assign out_count = out_count_q;
    assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_bundler_stream.sv
// Bench for bundler_stream: two instances (both tie modes) share stimulus and are checked
// every cycle against a queue-based majority model plus directed literal expectations.
module tb_bundler_stream;

    localparam int D  = 8;
    localparam int M  = 4;
    localparam int CW = 3;

    localparam int POpen    = 0;
    localparam int PVote    = 1;
    localparam int PWait    = 2;
    localparam int PPresent = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [D-1:0]  in_hv = '0;
    logic          out_ready = 1'b1;

    logic          ir0, ov0, tr0, ir1, ov1, tr1;
    logic [D-1:0]  hv0, hv1;
    logic [CW-1:0] cnt0, cnt1;

    int n_chk = 0;
    int n_bad = 0;

    bundler_stream #(.DIMENSIONS(D), .MAX_HVS(M), .TIE_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_hv(in_hv),
        .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_hv(hv0),
        .out_count(cnt0), .out_trunc(tr0)
    );

    bundler_stream #(.DIMENSIONS(D), .MAX_HVS(M), .TIE_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_hv(in_hv),
        .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_hv(hv1),
        .out_count(cnt1), .out_trunc(tr1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the current bundle is kept as a queue of accepted vectors.
    logic [D-1:0]  mq[$];
    int            phase = POpen;
    bit            m_live = 0;
    bit            m_ir, m_ov, m_tr, m_pend_tr;
    logic [D-1:0]  m_hv0, m_hv1;
    logic [CW-1:0] m_cnt;

    function automatic logic [D-1:0] majority(input int mode);
        logic [D-1:0] r, v, f, l;
        int ones, n, nb;
        n = mq.size();
        f = mq[0];
        l = mq[n-1];
        for (int i = 0; i < D; i++) begin
            ones = 0;
            for (int k = 0; k < n; k++) begin
                v = mq[k];
                ones += int'(v[i]);
            end
            nb = (i + 1) % D;
            if (2 * ones > n)      r[i] = 1'b1;
            else if (2 * ones < n) r[i] = 1'b0;
            else                   r[i] = (mode == 0) ? (f[nb] ^ l[nb]) : 1'b0;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            phase = POpen;
            m_ir = 1; m_ov = 0; m_tr = 0; m_pend_tr = 0;
            m_hv0 = '0; m_hv1 = '0; m_cnt = '0;
            m_live = 1;
        end else begin
            case (phase)
                POpen: if (in_valid) begin
                    mq.push_back(in_hv);
                    if (in_last || mq.size() == M) begin
                        m_pend_tr = !in_last;
                        m_ir = 0;
                        phase = PVote;
                    end
                end
                PVote: begin
                    m_hv0 = majority(0);
                    m_hv1 = majority(1);
                    m_cnt = CW'(mq.size());
                    m_tr  = m_pend_tr;
                    phase = PWait;
                end
                PWait: begin
                    m_ov  = 1;
                    phase = PPresent;
                end
                default: if (out_ready) begin
                    m_ov = 0;
                    m_ir = 1;
                    mq.delete();
                    phase = POpen;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready0", ir0, m_ir);    chk("in_ready1", ir1, m_ir);
            chk("out_valid0", ov0, m_ov);   chk("out_valid1", ov1, m_ov);
            chk("out_hv0", hv0, m_hv0);     chk("out_hv1", hv1, m_hv1);
            chk("out_count0", cnt0, m_cnt); chk("out_count1", cnt1, m_cnt);
            chk("out_trunc0", tr0, m_tr);   chk("out_trunc1", tr1, m_tr);
        end
    end

    task automatic send(input logic [D-1:0] hv, input logic last);
        bit ok, done;
        done = 0;
        in_valid = 1; in_hv = hv; in_last = last;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            ok = ir0;
            @(posedge clk);
            #1;
            done = ok;
        end
        if (!done) begin
            n_chk++; n_bad++;
            $display("FAIL send_timeout: vector %0h not accepted within 50 cycles", hv);
        end
        in_valid = 0; in_last = 0;
    endtask

    task automatic collect(input logic [D-1:0] e0, input logic [D-1:0] e1,
                           input int ecnt, input logic etr, output int lat);
        lat = 0;
        out_ready = 1;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk);
            if (ov0) lat = k;
        end
        if (lat == 0) begin
            n_chk++; n_bad++;
            $display("FAIL collect_timeout: out_valid never rose, want hv %0h", e0);
        end else begin
            chk("lit_hv0", hv0, e0);
            chk("lit_hv1", hv1, e1);
            chk("lit_count", cnt0, ecnt);
            chk("lit_trunc", tr0, etr);
            chk("lit_model_hv0", m_hv0, e0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_in_ready", ir0, 1);
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_hv", hv0, 0);
        chk("rst_out_count", cnt0, 0);
        chk("rst_out_trunc", tr0, 0);
        @(posedge clk);
        #1;

        // Odd-count majority and output latency
        send(8'hF0, 0); send(8'hCC, 0); send(8'hAA, 1);
        collect(8'hE8, 8'hE8, 3, 0, lat);
        chk("latency", lat, 3);

        // Even count with ties: mode 0 xors the next bit, mode 1 forces zero
        send(8'hC0, 0); send(8'hA0, 1);
        collect(8'hA0, 8'h80, 2, 0, lat);

        // Force-close at MAX_HVS
        for (int i = 0; i < M; i++) send(8'hFF, 0);
        @(negedge clk);
        chk("trunc_in_ready", ir0, 0);
        collect(8'hFF, 8'hFF, 4, 1, lat);

        // Backpressure with a pending source vector
        out_ready = 0;
        send(8'h5A, 1);
        lat = 0;
        for (int k = 0; k < 10 && lat == 0; k++) begin
            @(negedge clk);
            if (ov0) lat = 1;
        end
        chk("bp_valid_rise", ov0, 1);
        in_valid = 1; in_hv = 8'h0F; in_last = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", ov0, 1);
            chk("bp_hv", hv0, 8'h5A);
            chk("bp_count", cnt0, 1);
            chk("bp_ready", ir0, 0);
        end
        out_ready = 1;
        send(8'h0F, 1);
        collect(8'h0F, 8'h0F, 1, 0, lat);

        // Reset abandons a partial bundle
        send(8'h11, 0); send(8'h22, 0);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_mid_valid", ov0, 0);
        chk("rst_mid_ready", ir0, 1);
        send(8'h3C, 1);
        collect(8'h3C, 8'h3C, 1, 0, lat);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
